// File: rtl/ds_multi_sender.sv
// Periodic multi-destination sender: every PERIOD_CYCLES it emits one
// single-beat packet per enabled destination slot over a NAP data stream.
//
// Ports:
//   clk, resetn         clock, synchronous active-low reset
//   enable              period timer run (1) / hold at 0 (0)
//   dest_addr, dest_en  per-slot NoC address and enable mask
//   tx_valid/ready      data-stream handshake
//   tx_data, tx_addr    beat payload and destination address
//   tx_sop, tx_eop      packet framing (single-beat packets)
//   busy                burst in progress
//   sent_count          accepted beats (wrapping)
//   overrun_count       ticks lost while busy (saturating)
module ds_multi_sender #(
  parameter int DATA_WIDTH    = 256,
  parameter int ADDR_WIDTH    = 4,
  parameter int NUM_DEST      = 4,
  parameter int PERIOD_CYCLES = 25_000_000
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           enable,
  input  logic [NUM_DEST*ADDR_WIDTH-1:0] dest_addr,
  input  logic [NUM_DEST-1:0]            dest_en,
  output logic                           tx_valid,
  input  logic                           tx_ready,
  output logic [DATA_WIDTH-1:0]          tx_data,
  output logic [ADDR_WIDTH-1:0]          tx_addr,
  output logic                           tx_sop,
  output logic                           tx_eop,
  output logic                           busy,
  output logic [31:0]                    sent_count,
  output logic [15:0]                    overrun_count
);

  localparam int TW = (PERIOD_CYCLES > 2) ?
                      $clog2(PERIOD_CYCLES) : 1;
  localparam int IW = (NUM_DEST > 1) ?
                      $clog2(NUM_DEST) : 1;
  localparam logic [TW-1:0] TMAX =
    TW'(PERIOD_CYCLES - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [TW-1:0]                  r_timer;
  logic [NUM_DEST-1:0]            r_pend;
  logic [NUM_DEST*ADDR_WIDTH-1:0] r_addr;
  logic [7:0]                     r_burst_pl;
  logic [7:0]                     r_payload;
  logic [15:0]                    r_seq;
  logic [31:0]                    r_sent;
  logic [15:0]                    r_ovr;

  logic                w_tick;
  logic                w_start;
  logic                w_hs;
  logic                w_last;
  logic [IW-1:0]       w_slot;
  logic [NUM_DEST-1:0] w_onehot;
  logic [NUM_DEST-1:0] w_pend_nxt;

  // Period timer; held at 0 whenever enable is low.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_timer <= '0;
    end else if (!enable || (r_timer == TMAX)) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + TW'(1);
    end
  end

  assign w_tick  = enable && (r_timer == TMAX);
  assign w_start = (r_state == S_IDLE) && w_tick
                   && (|dest_en);
  assign w_hs    = tx_valid && tx_ready;

  // Lowest pending slot is the one on the wire.
  always_comb begin
    w_slot = '0;
    for (int i = NUM_DEST - 1; i >= 0; i--) begin
      if (r_pend[i]) begin
        w_slot = IW'(i);
      end
    end
  end

  assign w_onehot   = NUM_DEST'(1) << w_slot;
  assign w_pend_nxt = r_pend & ~w_onehot;
  assign w_last     = w_hs && (w_pend_nxt == '0);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        if (w_last) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Burst context is captured at the tick so that input
  // changes during a burst only affect the next one.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_pend     <= '0;
      r_addr     <= '0;
      r_burst_pl <= '0;
      r_payload  <= '0;
    end else if (w_start) begin
      r_pend     <= dest_en;
      r_addr     <= dest_addr;
      r_burst_pl <= r_payload;
      r_payload  <= r_payload + 8'd1;
    end else if (w_hs) begin
      r_pend <= w_pend_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_seq  <= '0;
      r_sent <= '0;
    end else if (w_hs) begin
      r_seq  <= r_seq + 16'd1;
      r_sent <= r_sent + 32'd1;
    end
  end

  // A tick while still sending is dropped and counted.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_ovr <= '0;
    end else if ((r_state == S_SEND) && w_tick
                 && (r_ovr != 16'hFFFF)) begin
      r_ovr <= r_ovr + 16'd1;
    end
  end

  // Beat fields come straight from registers, so they are
  // stable for as long as the sink stalls.
  always_comb begin
    tx_valid = 1'b0;
    tx_sop   = 1'b0;
    tx_eop   = 1'b0;
    tx_addr  = '0;
    tx_data  = '0;
    if (r_state == S_SEND) begin
      tx_valid = 1'b1;
      tx_sop   = 1'b1;
      tx_eop   = 1'b1;
      for (int i = 0; i < NUM_DEST; i++) begin
        if (IW'(i) == w_slot) begin
          tx_addr = r_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        end
      end
      tx_data = DATA_WIDTH'({r_seq,
                             {(8-IW){1'b0}}, w_slot,
                             r_burst_pl});
    end
  end

  assign busy          = (r_state == S_SEND);
  assign sent_count    = r_sent;
  assign overrun_count = r_ovr;

endmodule

// File: tb/tb_ds_multi_sender.sv
// Testbench for ds_multi_sender: directed bursts, scoreboard
// of expected beats checked by an independent monitor.
module tb_ds_multi_sender;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int ND = 4;
  localparam int PC = 10;

  logic          clk = 1'b0;
  logic          resetn;
  logic          enable;
  logic [ND*AW-1:0] dest_addr;
  logic [ND-1:0] dest_en;
  logic          tx_valid;
  logic          tx_ready;
  logic [DW-1:0] tx_data;
  logic [AW-1:0] tx_addr;
  logic          tx_sop;
  logic          tx_eop;
  logic          busy;
  logic [31:0]   sent_count;
  logic [15:0]   overrun_count;

  int n_checks = 0;
  int n_err    = 0;

  logic [AW+DW-1:0] exp_q[$];
  logic [15:0] exp_seq = '0;
  logic [7:0]  exp_payload = '0;

  logic             prev_stall = 1'b0;
  logic [AW+DW-1:0] prev_beat = '0;

  ds_multi_sender #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .NUM_DEST(ND),
    .PERIOD_CYCLES(PC)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .enable(enable),
    .dest_addr(dest_addr),
    .dest_en(dest_en),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx_data(tx_data),
    .tx_addr(tx_addr),
    .tx_sop(tx_sop),
    .tx_eop(tx_eop),
    .busy(busy),
    .sent_count(sent_count),
    .overrun_count(overrun_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_beat(input logic [AW-1:0] a,
                           input int slot);
    logic [7:0] s;
    s = 8'(slot);
    exp_q.push_back({a, exp_seq, s, exp_payload});
    exp_seq = exp_seq + 16'd1;
  endtask

  task automatic push_burst(input logic [ND-1:0] m,
                            input logic [ND*AW-1:0] a);
    for (int i = 0; i < ND; i++) begin
      if (m[i]) push_beat(a[i*AW +: AW], i);
    end
    exp_payload = exp_payload + 8'd1;
  endtask

  task automatic wait_valid(input int exp_lat);
    int lat;
    lat = 0;
    while (!tx_valid && lat < 40) begin
      step(1);
      lat++;
    end
    chk("valid_latency", 64'(lat), 64'(exp_lat));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 60) begin
      step(1);
      n++;
    end
    chk("burst_done", 64'(busy), 64'd0);
  endtask

  task automatic run_burst(input logic [ND-1:0] m,
                           input logic [ND*AW-1:0] a,
                           input int exp_len);
    int n;
    dest_en   = m;
    dest_addr = a;
    push_burst(m, a);
    enable = 1'b1;
    wait_valid(PC);
    enable = 1'b0;
    n = 0;
    while (tx_valid && n < 20) begin
      step(1);
      n++;
    end
    chk("burst_len", 64'(n), 64'(exp_len));
    wait_idle();
  endtask

  // Monitor: framing, hold-under-stall, scoreboard pop.
  always @(negedge clk) begin
    if (!resetn) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_hold_valid", 64'(tx_valid), 64'd1);
        chk("stall_hold_beat",
            64'({tx_addr, tx_data}), 64'(prev_beat));
      end
      if (tx_valid) begin
        chk("sop_eop", 64'({tx_sop, tx_eop}), 64'd3);
        if (tx_ready) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_beat: got %0h expected none",
                     {tx_addr, tx_data});
          end else begin
            logic [AW+DW-1:0] e;
            e = exp_q.pop_front();
            n_checks--;
            chk("beat", 64'({tx_addr, tx_data}), 64'(e));
          end
        end
      end
      prev_stall = tx_valid && !tx_ready;
      prev_beat  = {tx_addr, tx_data};
    end
  end

  initial begin
    int nv;
    resetn    = 1'b0;
    enable    = 1'b0;
    dest_en   = '0;
    dest_addr = 16'h4321;
    tx_ready  = 1'b1;
    step(2);
    chk("rst_valid", 64'(tx_valid), 64'd0);
    chk("rst_data", 64'(tx_data), 64'd0);
    chk("rst_addr", 64'(tx_addr), 64'd0);
    chk("rst_sop_eop", 64'({tx_sop, tx_eop}), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_sent", 64'(sent_count), 64'd0);
    chk("rst_ovr", 64'(overrun_count), 64'd0);
    resetn = 1'b1;
    step(1);

    // Zero mask for three ticks, then slot 0.
    enable = 1'b1;
    nv = 0;
    for (int i = 0; i < 3 * PC; i++) begin
      step(1);
      if (tx_valid || busy) nv++;
    end
    chk("zero_mask_quiet", 64'(nv), 64'd0);
    chk("zero_mask_ovr", 64'(overrun_count), 64'd0);
    dest_en = 4'b0001;
    push_burst(4'b0001, 16'h4321);
    wait_valid(PC);
    enable = 1'b0;
    wait_idle();
    chk("sent_after_zm", 64'(sent_count), 64'd1);

    // Basic burst: slots 0,1,3 back to back.
    run_burst(4'b1011, 16'h4321, 3);
    chk("sent_after_basic", 64'(sent_count), 64'd4);

    // Backpressure on slot 1 for 5 cycles.
    tx_ready  = 1'b0;
    dest_en   = 4'b0110;
    dest_addr = 16'h4321;
    push_burst(4'b0110, 16'h4321);
    enable = 1'b1;
    wait_valid(PC);
    enable = 1'b0;
    chk("bp_first_addr", 64'(tx_addr), 64'd2);
    step(5);
    tx_ready = 1'b1;
    wait_idle();
    chk("sent_after_bp", 64'(sent_count), 64'd6);

    // Overrun: ticks in cycles 19 and 29 hit a stalled burst.
    tx_ready = 1'b0;
    dest_en  = 4'b0001;
    push_burst(4'b0001, 16'h4321);
    enable = 1'b1;
    wait_valid(PC);
    step(20);
    tx_ready = 1'b1;
    enable   = 1'b0;
    wait_idle();
    chk("overrun", 64'(overrun_count), 64'd2);
    chk("sent_after_ovr", 64'(sent_count), 64'd7);

    // Inputs change during a burst.
    tx_ready  = 1'b0;
    dest_en   = 4'b1111;
    dest_addr = 16'h8765;
    push_burst(4'b1111, 16'h8765);
    enable = 1'b1;
    wait_valid(PC);
    dest_en   = 4'b0001;
    dest_addr = 16'h9999;
    enable    = 1'b0;
    tx_ready  = 1'b1;
    wait_idle();
    run_burst(4'b0001, 16'h9999, 1);
    chk("sent_after_mid", 64'(sent_count), 64'd12);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    // Reset in the middle of a stalled burst.
    tx_ready  = 1'b0;
    dest_en   = 4'b1111;
    dest_addr = 16'h4321;
    enable    = 1'b1;
    wait_valid(PC);
    enable = 1'b0;
    resetn = 1'b0;
    step(1);
    chk("mid_rst_valid", 64'(tx_valid), 64'd0);
    chk("mid_rst_data", 64'(tx_data), 64'd0);
    chk("mid_rst_addr", 64'(tx_addr), 64'd0);
    chk("mid_rst_sop_eop", 64'({tx_sop, tx_eop}), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_sent", 64'(sent_count), 64'd0);
    chk("mid_rst_ovr", 64'(overrun_count), 64'd0);
    resetn      = 1'b1;
    tx_ready    = 1'b1;
    exp_seq     = '0;
    exp_payload = '0;
    step(3);
    chk("no_resume", 64'(busy), 64'd0);
    run_burst(4'b0100, 16'h4321, 1);
    chk("sent_after_rst", 64'(sent_count), 64'd1);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    step(2);
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule
